// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet types, header length and rx parser state encoding
package eth_pkg;
  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] eth_type_t;
  localparam int ETH_HDR_BYTES = 14;
  typedef enum logic {S_HEADER, S_PAYLOAD} rx_state_t;
endpackage

// File: rtl/axis_pipeline_reg.sv
// axis_pipeline_reg: single-stage registered AXI-Stream slice carrying tdata/tlast/tuser
module axis_pipeline_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic         s_tlast,
  input  logic         s_tuser,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic         m_tuser
);
  logic [W-1:0] tdata_q, tdata_d;
  logic valid_q, valid_d, last_q, last_d, user_q, user_d;
  logic load;
  assign s_tready = m_tready || !valid_q;
  assign load = s_tready && s_tvalid;
  always_comb begin
    valid_d = s_tready ? s_tvalid : valid_q;
    tdata_d = load ? s_tdata : tdata_q;
    last_d = load ? s_tlast : last_q;
    user_d = load ? s_tuser : user_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      tdata_q <= '0;
      last_q <= 1'b0;
      user_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tdata_q <= tdata_d;
      last_q <= last_d;
      user_q <= user_d;
    end
  end
  assign m_tdata = tdata_q;
  assign m_tvalid = valid_q;
  assign m_tlast = last_q;
  assign m_tuser = user_q;
endmodule

// File: rtl/eth_axis_rx_parser.sv
// eth_axis_rx_parser: splits a raw byte-wide Ethernet frame stream into a header channel and a payload stream
module eth_axis_rx_parser
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HDR_BYTES = ETH_HDR_BYTES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output mac_addr_t             m_eth_dest_mac,
  output mac_addr_t             m_eth_src_mac,
  output eth_type_t             m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy,
  output logic                  error_header_early_termination
);
  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("eth_axis_rx_parser: only DATA_WIDTH = 8 is supported");
  end
  rx_state_t state_q, state_d;
  logic [3:0] hdr_cnt_q, hdr_cnt_d;
  mac_addr_t dest_q, dest_d, src_q, src_d;
  eth_type_t type_q, type_d;
  logic hdr_valid_q, hdr_valid_d, busy_q, busy_d, err_q, err_d;
  logic in_hdr, pipe_ready, hdr_acc, pay_acc;
  assign in_hdr = state_q == S_HEADER;
  assign s_axis_tready = in_hdr ? !hdr_valid_q : pipe_ready;
  assign hdr_acc = in_hdr && s_axis_tvalid && s_axis_tready;
  assign pay_acc = !in_hdr && s_axis_tvalid && pipe_ready;
  always_comb begin
    state_d = state_q;
    hdr_cnt_d = hdr_cnt_q;
    dest_d = dest_q;
    src_d = src_q;
    type_d = type_q;
    hdr_valid_d = hdr_valid_q && !m_eth_hdr_ready;
    busy_d = busy_q;
    err_d = 1'b0;
    if (hdr_acc) begin
      dest_d = hdr_cnt_q < 4'd6 ? {dest_q[39:0], s_axis_tdata} : dest_q;
      src_d = (hdr_cnt_q >= 4'd6 && hdr_cnt_q < 4'd12) ? {src_q[39:0], s_axis_tdata} : src_q;
      type_d = hdr_cnt_q >= 4'd12 ? {type_q[7:0], s_axis_tdata} : type_q;
      hdr_cnt_d = (s_axis_tlast || hdr_cnt_q == 4'(HDR_BYTES - 1)) ? 4'd0 : hdr_cnt_q + 4'd1;
      busy_d = !s_axis_tlast;
      err_d = s_axis_tlast;
      hdr_valid_d = !s_axis_tlast && hdr_cnt_q == 4'(HDR_BYTES - 1);
      state_d = hdr_valid_d ? S_PAYLOAD : S_HEADER;
    end
    if (pay_acc && s_axis_tlast) begin
      state_d = S_HEADER;
      busy_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_HEADER;
      hdr_cnt_q <= '0;
      dest_q <= '0;
      src_q <= '0;
      type_q <= '0;
      hdr_valid_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      dest_q <= dest_d;
      src_q <= src_d;
      type_q <= type_d;
      hdr_valid_q <= hdr_valid_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  // tuser is only meaningful on the frame's final byte
  axis_pipeline_reg #(.W(DATA_WIDTH)) u_pay (
    .clk(clk),
    .reset(reset),
    .s_tdata(s_axis_tdata),
    .s_tvalid(s_axis_tvalid && !in_hdr),
    .s_tready(pipe_ready),
    .s_tlast(s_axis_tlast),
    .s_tuser(s_axis_tuser && s_axis_tlast),
    .m_tdata(m_eth_payload_axis_tdata),
    .m_tvalid(m_eth_payload_axis_tvalid),
    .m_tready(m_eth_payload_axis_tready),
    .m_tlast(m_eth_payload_axis_tlast),
    .m_tuser(m_eth_payload_axis_tuser)
  );
  assign m_eth_hdr_valid = hdr_valid_q;
  assign m_eth_dest_mac = dest_q;
  assign m_eth_src_mac = src_q;
  assign m_eth_type = type_q;
  assign busy = busy_q;
  assign error_header_early_termination = err_q;
endmodule

// File: tb/tb_eth_axis_rx_parser.sv
// tb_eth_axis_rx_parser: randomized frames checked against a frame-level reference model
module tb_eth_axis_rx_parser;
  logic clk = 1'b0, reset = 1'b0;
  logic [7:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic hdr_valid, hdr_ready = 1'b1;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] eth_type;
  logic [7:0] pay_tdata;
  logic pay_tvalid, pay_tready = 1'b1, pay_tlast, pay_tuser;
  logic busy, err;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] tx_q[$];
  logic [111:0] exp_hdr[$], got_hdr[$];
  logic [9:0] exp_pay[$], got_pay[$];
  int err_hi, err_cyc, hdr_rise_cyc, busy_fall_cyc, hdr_acc_first, pay_first_cyc, stab_viol;
  int b0_cyc, b13_cyc, tlast_cyc, drv_idx;
  bit pay_rand = 0, abort = 0;
  logic prev_valid = 0, prev_busy = 0, prev_stall = 0;
  logic [111:0] prev_hdr = '0;

  eth_axis_rx_parser dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_eth_hdr_valid(hdr_valid), .m_eth_hdr_ready(hdr_ready),
    .m_eth_dest_mac(dest_mac), .m_eth_src_mac(src_mac), .m_eth_type(eth_type),
    .m_eth_payload_axis_tdata(pay_tdata), .m_eth_payload_axis_tvalid(pay_tvalid),
    .m_eth_payload_axis_tready(pay_tready), .m_eth_payload_axis_tlast(pay_tlast),
    .m_eth_payload_axis_tuser(pay_tuser),
    .busy(busy), .error_header_early_termination(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 pay_tready = pay_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (hdr_valid && hdr_ready) begin
      got_hdr.push_back({dest_mac, src_mac, eth_type});
      if (hdr_acc_first < 0) hdr_acc_first = cyc;
    end
    if (pay_tvalid && pay_tready) got_pay.push_back({pay_tuser, pay_tlast, pay_tdata});
    if (pay_tvalid && pay_first_cyc < 0) pay_first_cyc = cyc;
    if (err) begin err_hi++; err_cyc = cyc; end
    if (hdr_valid && !prev_valid) hdr_rise_cyc = cyc;
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    if (prev_stall && reset && !(hdr_valid && {dest_mac, src_mac, eth_type} == prev_hdr)) stab_viol++;
    prev_stall = hdr_valid && !hdr_ready;
    prev_hdr = {dest_mac, src_mac, eth_type};
    prev_valid = hdr_valid;
    prev_busy = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear();
    tx_q.delete(); exp_hdr.delete(); got_hdr.delete(); exp_pay.delete(); got_pay.delete();
    err_hi = 0; err_cyc = -1; hdr_rise_cyc = -1; busy_fall_cyc = -1;
    hdr_acc_first = -1; pay_first_cyc = -1; stab_viol = 0; drv_idx = -1;
  endtask

  task automatic make_frame(input int len);
    tx_q.delete();
    for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: frames of 14 bytes or fewer are errors; otherwise bytes 0..13 form the header, the rest is payload
  task automatic model_frame(input bit tuser);
    logic [111:0] h;
    int n;
    n = tx_q.size();
    if (n <= 14) return;
    h = '0;
    for (int i = 0; i < 14; i++) h[111 - 8 * i -: 8] = tx_q[i];
    exp_hdr.push_back(h);
    for (int i = 14; i < n; i++) exp_pay.push_back({tuser && i == n - 1, i == n - 1, tx_q[i]});
  endtask

  function automatic int pay_diff();
    int d;
    d = got_pay.size() - exp_pay.size();
    if (d < 0) d = -d;
    foreach (exp_pay[i]) if (i < got_pay.size() && got_pay[i] !== exp_pay[i]) d++;
    return d;
  endfunction

  function automatic int hdr_diff();
    int d;
    d = got_hdr.size() - exp_hdr.size();
    if (d < 0) d = -d;
    foreach (exp_hdr[i]) if (i < got_hdr.size() && got_hdr[i] !== exp_hdr[i]) d++;
    return d;
  endfunction

  task automatic send_frame(input bit tuser);
    int t;
    bit acc;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (abort) break;
      drv_idx = i;
      s_tdata = tx_q[i];
      s_tvalid = 1'b1;
      s_tlast = i == tx_q.size() - 1;
      s_tuser = tuser && s_tlast;
      t = 0;
      acc = 0;
      do begin
        @(negedge clk) acc = s_tready;
        @(posedge clk);
        #1 t++;
      end while (!acc && !abort && t < 2000);
      if (!acc && !abort) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0d still not accepted after %0d cycles, required acceptance", i, t);
        break;
      end
      if (i == 0) b0_cyc = cyc;
      if (i == 13) b13_cyc = cyc;
      if (s_tlast) tlast_cyc = cyc;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b, required 1", s_tready); end
    if (hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid: got %b, required 0", hdr_valid); end
    if ({dest_mac, src_mac, eth_type} !== 112'h0) begin errors++; $display("FAIL reset_hdr_fields: got %h, required 0", {dest_mac, src_mac, eth_type}); end
    if ({pay_tvalid, pay_tlast, pay_tuser, pay_tdata} !== 11'h0) begin errors++; $display("FAIL reset_payload: got %h, required 0", {pay_tvalid, pay_tlast, pay_tuser, pay_tdata}); end
    if ({busy, err} !== 2'b00) begin errors++; $display("FAIL reset_busy_err: got %b, required 00", {busy, err}); end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_basic_frame();
    clear();
    for (int i = 0; i < 12; i++) tx_q.push_back(8'(i * 8'h11));
    tx_q.push_back(8'h08); tx_q.push_back(8'h00);
    for (int i = 0; i <= 8'h2D; i++) tx_q.push_back(8'(i));
    model_frame(0);
    send_frame(0);
    repeat (6) @(posedge clk);
    #1 checks += 7;
    if (got_hdr.size() != 1 || got_hdr[0] !== 112'h001122334455_66778899AABB_0800) begin
      errors++; $display("FAIL basic_hdr_const: got %0d headers first %h, required 1 header 001122334455_66778899aabb_0800", got_hdr.size(), got_hdr.size() ? got_hdr[0] : 112'h0);
    end
    if (hdr_diff() != 0) begin errors++; $display("FAIL basic_hdr: %0d headers with %0d differences, required %0d and 0", got_hdr.size(), hdr_diff(), exp_hdr.size()); end
    if (pay_diff() != 0) begin errors++; $display("FAIL basic_payload: %0d bytes with %0d differences, required %0d and 0", got_pay.size(), pay_diff(), exp_pay.size()); end
    if (hdr_rise_cyc != b13_cyc) begin errors++; $display("FAIL basic_hdr_timing: hdr_valid rose at cycle %0d, required %0d", hdr_rise_cyc, b13_cyc); end
    if (pay_first_cyc != b13_cyc + 1) begin errors++; $display("FAIL basic_pay_latency: first payload at cycle %0d, required %0d", pay_first_cyc, b13_cyc + 1); end
    if (busy_fall_cyc != tlast_cyc) begin errors++; $display("FAIL basic_busy_fall: busy fell at cycle %0d, required %0d", busy_fall_cyc, tlast_cyc); end
    if (err_hi != 0) begin errors++; $display("FAIL basic_no_error: error high %0d cycles, required 0", err_hi); end
  endtask

  task automatic test_early_term();
    clear();
    make_frame(10);
    model_frame(0);
    send_frame(0);
    repeat (5) @(posedge clk);
    #1 checks += 4;
    if (err_hi != 1) begin errors++; $display("FAIL early_err_width: error high %0d cycles, required 1", err_hi); end
    if (err_cyc != tlast_cyc) begin errors++; $display("FAIL early_err_timing: pulse at cycle %0d, required %0d", err_cyc, tlast_cyc); end
    if (hdr_rise_cyc != -1 || got_hdr.size() != 0) begin errors++; $display("FAIL early_no_hdr: hdr_valid rose at %0d with %0d headers, required never and 0", hdr_rise_cyc, got_hdr.size()); end
    if (got_pay.size() != 0) begin errors++; $display("FAIL early_no_payload: got %0d bytes, required 0", got_pay.size()); end
    clear();
    make_frame(14 + $urandom_range(1, 30));
    model_frame(0);
    send_frame(0);
    repeat (6) @(posedge clk);
    #1 checks += 3;
    if (hdr_diff() != 0) begin errors++; $display("FAIL early_next_hdr: %0d headers with %0d differences, required %0d and 0", got_hdr.size(), hdr_diff(), exp_hdr.size()); end
    if (pay_diff() != 0) begin errors++; $display("FAIL early_next_payload: %0d bytes with %0d differences, required %0d and 0", got_pay.size(), pay_diff(), exp_pay.size()); end
    if (err_hi != 0) begin errors++; $display("FAIL early_next_no_error: error high %0d cycles, required 0", err_hi); end
  endtask

  task automatic test_no_payload();
    clear();
    make_frame(14);
    model_frame(0);
    send_frame(0);
    repeat (5) @(posedge clk);
    #1 checks += 4;
    if (err_hi != 1) begin errors++; $display("FAIL hdr_only_err: error high %0d cycles, required 1", err_hi); end
    if (got_hdr.size() != 0 || hdr_rise_cyc != -1) begin errors++; $display("FAIL hdr_only_no_hdr: got %0d headers, required 0", got_hdr.size()); end
    if (got_pay.size() != 0) begin errors++; $display("FAIL hdr_only_no_payload: got %0d bytes, required 0", got_pay.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL hdr_only_busy: got %b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    clear();
    hdr_ready = 1'b0;
    fork
      begin
        make_frame(34); model_frame(0); send_frame(0);
        make_frame(40); model_frame(0); send_frame(0);
      end
      begin
        repeat (50) @(posedge clk);
        #1 checks += 2;
        if (got_pay.size() != 20 || got_pay[got_pay.size() - 1][8] !== 1'b1) begin
          errors++; $display("FAIL stall_first_payload: got %0d bytes before header accept, required 20 ending in tlast", got_pay.size());
        end
        if (s_tready !== 1'b0 || drv_idx != 0) begin errors++; $display("FAIL stall_tready: tready %b at byte %0d, required 0 at byte 0", s_tready, drv_idx); end
        hdr_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1 checks += 4;
    if (b0_cyc != hdr_acc_first + 2) begin errors++; $display("FAIL stall_byte0_release: byte 0 accepted at %0d, required %0d", b0_cyc, hdr_acc_first + 2); end
    if (hdr_diff() != 0) begin errors++; $display("FAIL stall_hdrs: %0d headers with %0d differences, required %0d and 0", got_hdr.size(), hdr_diff(), exp_hdr.size()); end
    if (pay_diff() != 0) begin errors++; $display("FAIL stall_payload: %0d bytes with %0d differences, required %0d and 0", got_pay.size(), pay_diff(), exp_pay.size()); end
    if (stab_viol != 0) begin errors++; $display("FAIL stall_hdr_stable: %0d changes while stalled, required 0", stab_viol); end
  endtask

  task automatic test_random_backpressure();
    int users;
    clear();
    make_frame(114);
    model_frame(1);
    pay_rand = 1;
    send_frame(1);
    pay_rand = 0;
    repeat (6) @(posedge clk);
    #1 checks += 3;
    users = 0;
    foreach (got_pay[i]) users += int'(got_pay[i][9]);
    if (pay_diff() != 0) begin errors++; $display("FAIL bp_payload: %0d bytes with %0d differences, required %0d and 0", got_pay.size(), pay_diff(), exp_pay.size()); end
    if (users != 1 || got_pay.size() == 0 || got_pay[got_pay.size() - 1][9] !== 1'b1) begin
      errors++; $display("FAIL bp_tuser: %0d bytes flagged, required exactly the last one", users);
    end
    if (hdr_diff() != 0) begin errors++; $display("FAIL bp_hdr: %0d headers with %0d differences, required %0d and 0", got_hdr.size(), hdr_diff(), exp_hdr.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int t, lasts;
    clear();
    make_frame(74);
    fork
      send_frame(0);
      begin
        t = 0;
        do begin
          @(posedge clk);
          #2 t++;
        end while (drv_idx < 34 && t < 500);
        if (t >= 500) begin checks++; errors++; $display("FAIL midrst_wait: payload byte 20 not reached in %0d cycles", t); end
        abort = 1; reset = 1'b0; s_tvalid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks += 5;
        if (s_tready !== 1'b1) begin errors++; $display("FAIL midrst_tready: got %b, required 1", s_tready); end
        if (hdr_valid !== 1'b0) begin errors++; $display("FAIL midrst_hdr_valid: got %b, required 0", hdr_valid); end
        if ({dest_mac, src_mac, eth_type} !== 112'h0) begin errors++; $display("FAIL midrst_hdr_fields: got %h, required 0", {dest_mac, src_mac, eth_type}); end
        if ({pay_tvalid, pay_tlast, pay_tuser, pay_tdata} !== 11'h0) begin errors++; $display("FAIL midrst_payload: got %h, required 0", {pay_tvalid, pay_tlast, pay_tuser, pay_tdata}); end
        if ({busy, err} !== 2'b00) begin errors++; $display("FAIL midrst_busy_err: got %b, required 00", {busy, err}); end
      end
    join
    abort = 0;
    lasts = 0;
    foreach (got_pay[i]) lasts += int'(got_pay[i][8]);
    checks++;
    if (lasts != 0) begin errors++; $display("FAIL midrst_no_tlast: %0d tlast bytes from dropped frame, required 0", lasts); end
    @(posedge clk);
    #1 clear();
    make_frame(14 + $urandom_range(5, 40));
    model_frame(0);
    send_frame(0);
    repeat (6) @(posedge clk);
    #1 checks += 2;
    if (hdr_diff() != 0) begin errors++; $display("FAIL midrst_next_hdr: %0d headers with %0d differences, required %0d and 0", got_hdr.size(), hdr_diff(), exp_hdr.size()); end
    if (pay_diff() != 0) begin errors++; $display("FAIL midrst_next_payload: %0d bytes with %0d differences, required %0d and 0", got_pay.size(), pay_diff(), exp_pay.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_early_term();
    test_no_payload();
    test_back_to_back();
    test_random_backpressure();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
